// File: rtl/apb_regs_pkg.sv
// Register map offsets, CTRL bit positions and APB bus phase encoding
// shared by the register-file slave and anything that talks to it.
package apb_regs_pkg;

    localparam logic [31:0] CTRL_OFFSET   = 32'h0;
    localparam logic [31:0] STATUS_OFFSET = 32'h4;
    localparam logic [31:0] GP_OFFSET     = 32'h8;

    localparam int CTRL_START_BIT = 0;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_phase_e;

endpackage

// File: rtl/apb_slave_regfile.sv
// APB3 slave (no pslverr) in front of the matrix-multiplier register bank:
// CTRL with self-clearing start bit, read-only STATUS, general-purpose RW words.
module apb_slave_regfile
    import apb_regs_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    output logic                           pready,
    output logic [DATA_WIDTH-1:0]          prdata,
    input  logic [DATA_WIDTH-1:0]          status_i,
    output logic                           start_o,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int CNT_W = 4;

    localparam logic [IDX_W-1:0] CTRL_IDX   = IDX_W'(CTRL_OFFSET >> 2);
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(STATUS_OFFSET >> 2);
    localparam logic [IDX_W-1:0] GP_IDX     = IDX_W'(GP_OFFSET >> 2);

    localparam logic [DATA_WIDTH-1:0] START_MASK = DATA_WIDTH'(1) << CTRL_START_BIT;

    apb_phase_e phase;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  start_q, start_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic [IDX_W-1:0]      idx;
    logic                  in_range;
    logic                  wr_commit;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_addr_lsbs;

    assign idx              = paddr[IDX_W+1:2];
    assign in_range         = (paddr >> (IDX_W + 2)) == '0;
    assign unused_addr_lsbs = ^paddr[1:0];

    always_comb begin
        phase = IDLE;
        if (psel) begin
            phase = penable ? ACCESS : SETUP;
        end
    end

    // Gated by preset so a transfer caught by reset never looks complete.
    assign pready    = (phase == ACCESS) && (cnt_q == '0) && !preset;
    assign wr_commit = pready && pwrite && in_range;

    always_comb begin
        cnt_d = cnt_q;
        case (phase)
            SETUP:   cnt_d = CNT_W'(WAIT_STATES);
            ACCESS:  if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        rd_word = '0;
        if (in_range) begin
            rd_word = (idx == STATUS_IDX) ? status_i : regs_q[idx];
        end
    end

    always_comb begin
        prdata_d = prdata_q;
        if (phase == SETUP && !pwrite) begin
            prdata_d = rd_word;
        end
    end

    // STATUS slot has no storage; CTRL keeps everything except the start bit.
    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_d[k] = regs_q[k];
        end
        if (wr_commit) begin
            if (idx == CTRL_IDX) begin
                regs_d[CTRL_IDX] = pwdata & ~START_MASK;
            end else if (idx >= GP_IDX) begin
                regs_d[idx] = pwdata;
            end
        end
        regs_d[STATUS_IDX] = '0;
    end

    assign start_d = wr_commit && (idx == CTRL_IDX) && pwdata[CTRL_START_BIT];

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            cnt_q    <= '0;
            prdata_q <= '0;
            start_q  <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            prdata_q <= prdata_d;
            start_q  <= start_d;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    assign prdata  = prdata_q;
    assign start_o = start_q;

    always_comb begin
        regs_o = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_o[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: two instances (0 and 2 wait states) on a shared
// bus, checked against an address-level register model.
module tb_apb_slave_regfile;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 8;

    logic          pclk = 1'b0;
    logic          preset;
    logic [AW-1:0] paddr;
    logic          psel0, psel2;
    logic          penable, pwrite;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] status_i;
    logic          pready0, pready2;
    logic [DW-1:0] prdata0, prdata2;
    logic          start0, start2;
    logic [NR*DW-1:0] regs0, regs2;

    logic [31:0] mdl [2][NR];
    logic [31:0] last_rd [2];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 pclk = ~pclk;

    apb_slave_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(0)) u_dut0 (
        .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready0), .prdata(prdata0),
        .status_i(status_i), .start_o(start0), .regs_o(regs0)
    );

    apb_slave_regfile #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(2)) u_dut2 (
        .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel2), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pready(pready2), .prdata(prdata2),
        .status_i(status_i), .start_o(start2), .regs_o(regs2)
    );

    function automatic void model_clear();
        for (int w = 0; w < 2; w++) begin
            last_rd[w] = '0;
            for (int k = 0; k < NR; k++) mdl[w][k] = '0;
        end
    endfunction

    function automatic logic [31:0] model_read(int w, logic [31:0] a, logic [31:0] st);
        int k;
        if (a >= 32'(4 * NR)) return '0;
        k = int'(a >> 2);
        if (k == 1) return st;
        return mdl[w][k];
    endfunction

    function automatic void model_write(int w, logic [31:0] a, logic [31:0] d);
        int k;
        if (a >= 32'(4 * NR)) return;
        k = int'(a >> 2);
        if (k == 0) mdl[w][0] = d & 32'hFFFF_FFFE;
        else if (k != 1) mdl[w][k] = d;
    endfunction

    function automatic int ws_of(int w);
        return (w == 0) ? 0 : 2;
    endfunction

    // Runs SETUP then ACCESS; returns just before the completing edge.
    task automatic apb_xfer(input int w, input bit wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] st, output logic [31:0] rd, output int waits,
                            output bit stable);
        logic [31:0] first;
        @(negedge pclk);
        status_i = st;
        psel0    = (w == 0);
        psel2    = (w == 1);
        penable  = 1'b0;
        pwrite   = wr;
        paddr    = a;
        pwdata   = d;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        status_i = $urandom;
        first  = (w == 0) ? prdata0 : prdata2;
        stable = 1'b1;
        waits  = 0;
        while (((w == 0) ? pready0 : pready2) !== 1'b1) begin
            if (waits > 40) begin
                n_checks++;
                $display("FAIL pready_timeout: dut%0d addr %h, no pready after %0d cycles, required within %0d",
                         w, a, waits, ws_of(w));
                break;
            end
            @(negedge pclk);
            #1;
            waits++;
            if (((w == 0) ? prdata0 : prdata2) !== first) stable = 1'b0;
        end
        rd = (w == 0) ? prdata0 : prdata2;
    endtask

    task automatic bus_idle();
        @(negedge pclk);
        psel0   = 1'b0;
        psel2   = 1'b0;
        penable = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        preset = 1'b1;
        psel0 = 0; psel2 = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; status_i = '0;
        model_clear();
        repeat (3) @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);
        #1;
        n_checks++;
        if (pready0 !== 1'b0 || pready2 !== 1'b0) $display("FAIL reset_pready: got %b/%b required 0/0", pready0, pready2);
        else n_pass++;
        n_checks++;
        if (prdata0 !== '0 || prdata2 !== '0) $display("FAIL reset_prdata: got %h/%h required 0", prdata0, prdata2);
        else n_pass++;
        n_checks++;
        if (regs0 !== '0 || regs2 !== '0) $display("FAIL reset_regs: got %h / %h required 0", regs0, regs2);
        else n_pass++;
        n_checks++;
        if (start0 !== 1'b0 || start2 !== 1'b0) $display("FAIL reset_start: got %b/%b required 0/0", start0, start2);
        else n_pass++;
    endtask

    task automatic test_basic_ws0();
        logic [31:0] rd; int waits; bit stable;
        apb_xfer(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 32'h0, rd, waits, stable);
        model_write(0, 32'h8, 32'hDEAD_BEEF);
        n_checks++;
        if (waits !== 0) $display("FAIL ws0_write_latency: got %0d wait cycles required 0", waits);
        else n_pass++;
        apb_xfer(0, 1'b0, 32'h8, 32'h0, 32'h0, rd, waits, stable);
        last_rd[0] = rd;
        n_checks++;
        if (waits !== 0) $display("FAIL ws0_read_latency: got %0d wait cycles required 0", waits);
        else n_pass++;
        n_checks++;
        if (rd !== 32'hDEAD_BEEF) $display("FAIL ws0_read_data: got %h required DEADBEEF", rd);
        else n_pass++;
        bus_idle();
    endtask

    task automatic test_wait_states();
        logic [31:0] rd, d; int waits; bit stable;
        d = $urandom;
        apb_xfer(1, 1'b1, 32'hC, d, 32'h0, rd, waits, stable);
        model_write(1, 32'hC, d);
        apb_xfer(1, 1'b0, 32'hC, 32'h0, 32'h0, rd, waits, stable);
        last_rd[1] = rd;
        n_checks++;
        if (waits !== 2) $display("FAIL ws2_read_latency: got %0d wait cycles required 2", waits);
        else n_pass++;
        n_checks++;
        if (stable !== 1'b1) $display("FAIL ws2_prdata_stable: prdata moved during wait cycles, final %h", rd);
        else n_pass++;
        n_checks++;
        if (rd !== d) $display("FAIL ws2_read_data: got %h required %h", rd, d);
        else n_pass++;
        bus_idle();
    endtask

    task automatic test_ctrl_start();
        logic [31:0] rd; int waits; bit stable;
        apb_xfer(0, 1'b1, 32'h0, 32'h3, 32'h0, rd, waits, stable);
        model_write(0, 32'h0, 32'h3);
        n_checks++;
        if (start0 !== 1'b0) $display("FAIL start_early: got %b during ACCESS required 0", start0);
        else n_pass++;
        bus_idle();
        n_checks++;
        if (start0 !== 1'b1) $display("FAIL start_pulse: got %b after completing edge required 1", start0);
        else n_pass++;
        bus_idle();
        n_checks++;
        if (start0 !== 1'b0) $display("FAIL start_width: got %b one cycle later required 0", start0);
        else n_pass++;
        apb_xfer(0, 1'b0, 32'h0, 32'h0, 32'h0, rd, waits, stable);
        last_rd[0] = rd;
        n_checks++;
        if (rd !== 32'h2) $display("FAIL ctrl_readback: got %h required 00000002", rd);
        else n_pass++;
        apb_xfer(0, 1'b1, 32'h0, 32'h4, 32'h0, rd, waits, stable);
        model_write(0, 32'h0, 32'h4);
        bus_idle();
        n_checks++;
        if (start0 !== 1'b0) $display("FAIL start_spurious: got %b after writing bit0=0 required 0", start0);
        else n_pass++;
    endtask

    task automatic test_status_range();
        logic [31:0] rd; int waits; bit stable;
        apb_xfer(0, 1'b1, 32'h4, 32'h1234, 32'h55, rd, waits, stable);
        apb_xfer(0, 1'b0, 32'h4, 32'h0, 32'h55, rd, waits, stable);
        last_rd[0] = rd;
        n_checks++;
        if (rd !== 32'h55) $display("FAIL status_read: got %h required 00000055", rd);
        else n_pass++;
        apb_xfer(0, 1'b1, 32'h48, 32'hFFFF_FFFF, 32'h0, rd, waits, stable);
        apb_xfer(0, 1'b0, 32'h40, 32'h0, 32'h0, rd, waits, stable);
        last_rd[0] = rd;
        n_checks++;
        if (rd !== 32'h0) $display("FAIL oor_read: got %h required 0", rd);
        else n_pass++;
        apb_xfer(0, 1'b0, 32'h8, 32'h0, 32'h0, rd, waits, stable);
        last_rd[0] = rd;
        n_checks++;
        if (rd !== mdl[0][2]) $display("FAIL oor_write_alias: got %h required %h", rd, mdl[0][2]);
        else n_pass++;
        bus_idle();
        n_checks++;
        if (regs0[1*DW +: DW] !== '0) $display("FAIL status_word_export: got %h required 0", regs0[1*DW +: DW]);
        else n_pass++;
    endtask

    task automatic test_abort();
        logic [31:0] rd; int waits; bit stable;
        @(negedge pclk);
        psel2 = 1'b1; psel0 = 1'b0; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'hA5A5_0F0F;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        n_checks++;
        if (pready2 !== 1'b0) $display("FAIL abort_pready: got %b in first wait cycle required 0", pready2);
        else n_pass++;
        bus_idle();
        apb_xfer(1, 1'b0, 32'h10, 32'h0, 32'h0, rd, waits, stable);
        last_rd[1] = rd;
        n_checks++;
        if (rd !== mdl[1][4]) $display("FAIL abort_no_write: got %h required %h", rd, mdl[1][4]);
        else n_pass++;
        n_checks++;
        if (waits !== 2) $display("FAIL abort_reload: got %0d wait cycles required 2", waits);
        else n_pass++;
        bus_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, d [4]; int waits; bit stable;
        for (int i = 0; i < 4; i++) begin
            d[i] = $urandom;
            apb_xfer(1, 1'b1, 32'(8 + 4 * i), d[i], 32'h0, rd, waits, stable);
            model_write(1, 32'(8 + 4 * i), d[i]);
        end
        for (int i = 0; i < 4; i++) begin
            apb_xfer(1, 1'b0, 32'(8 + 4 * i), 32'h0, 32'h0, rd, waits, stable);
            last_rd[1] = rd;
            n_checks++;
            if (rd !== d[i] || waits !== 2)
                $display("FAIL b2b_read%0d: got %h after %0d waits required %h after 2", i, rd, waits, d[i]);
            else n_pass++;
        end
        bus_idle();
    endtask

    task automatic test_random_traffic();
        logic [31:0] rd, a, d, st, exp; int waits, w; bit stable, wr;
        for (int i = 0; i < 80; i++) begin
            w  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            d  = $urandom;
            st = $urandom;
            if ($urandom_range(0, 4) == 0) a = 32'(4 * NR) + ($urandom_range(0, 32'h3FF) << $urandom_range(0, 8));
            else a = 32'($urandom_range(0, NR - 1) * 4 + $urandom_range(0, 3));
            apb_xfer(w, wr, a, d, st, rd, waits, stable);
            if (wr) begin
                exp = last_rd[w];
                model_write(w, a, d);
            end else begin
                exp = model_read(w, a, st);
                last_rd[w] = exp;
            end
            n_checks++;
            if (rd !== exp || waits !== ws_of(w) || stable !== 1'b1)
                $display("FAIL rand%0d_dut%0d_%s@%h: got %h waits %0d stable %b required %h waits %0d stable 1",
                         i, w, wr ? "wr" : "rd", a, rd, waits, stable, exp, ws_of(w));
            else n_pass++;
            if ($urandom_range(0, 2) == 0) bus_idle();
        end
        bus_idle();
        for (int k = 0; k < NR; k++) begin
            n_checks++;
            if (regs0[k*DW +: DW] !== mdl[0][k] || regs2[k*DW +: DW] !== mdl[1][k])
                $display("FAIL regs_image_word%0d: got %h/%h required %h/%h", k,
                         regs0[k*DW +: DW], regs2[k*DW +: DW], mdl[0][k], mdl[1][k]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd; int waits; bit stable;
        @(negedge pclk);
        psel2 = 1'b1; psel0 = 1'b0; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'hCAFE_F00D;
        @(negedge pclk);
        penable = 1'b1;
        @(posedge pclk);
        #2;
        preset = 1'b1;
        #1;
        n_checks++;
        if (pready2 !== 1'b0) $display("FAIL rst_mid_pready: got %b required 0", pready2);
        else n_pass++;
        @(negedge pclk);
        psel2 = 1'b0; penable = 1'b0;
        @(negedge pclk);
        preset = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (regs2[5*DW +: DW] !== '0 || regs2 !== '0) $display("FAIL rst_mid_target: got %h required 0", regs2[5*DW +: DW]);
        else n_pass++;
        apb_xfer(1, 1'b0, 32'h14, 32'h0, 32'h0, rd, waits, stable);
        n_checks++;
        if (rd !== 32'h0 || waits !== 2) $display("FAIL rst_mid_readback: got %h after %0d waits required 0 after 2", rd, waits);
        else n_pass++;
        bus_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_ws0();
        test_wait_states();
        test_ctrl_start();
        test_status_range();
        test_abort();
        test_back_to_back();
        test_random_traffic();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
